// File: rtl/an_xmit_controller.sv
// an_xmit_controller: Clause 37 auto-negotiation sequencer driving xmit and tx_config_reg
module an_xmit_controller #(
  parameter int LINK_TIMER = 16,
  parameter int TMR_W = 16
) (
  input  logic        clk,
  input  logic        mr_main_reset,
  input  logic        mr_an_enable,
  input  logic        mr_restart_an,
  input  logic        sync_status,
  input  logic [15:0] mr_adv_ability,
  input  logic [1:0]  rudi,
  input  logic [15:0] rx_config_reg,
  output logic [2:0]  xmit,
  output logic [15:0] tx_config_reg,
  output logic        mr_an_complete,
  output logic        mr_page_rx,
  output logic [15:0] mr_lp_adv_ability
);
  typedef enum logic [2:0] {
    AN_ENABLE, AN_RESTART, ABILITY_DETECT, ACKNOWLEDGE_DETECT,
    COMPLETE_ACKNOWLEDGE, IDLE_DETECT, LINK_OK, AN_DISABLE_LINK_OK
  } state_t;
  localparam logic [15:0] ACK = 16'h4000;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(LINK_TIMER - 1);
  state_t state, state_nx;
  logic [1:0] abl_cnt, idle_cnt;
  logic [2:0] ack_hist;
  logic [15:0] abl_word, stored_abl, rx_masked, tx_d;
  logic [TMR_W-1:0] timer;
  logic [2:0] xmit_d;
  logic is_cfg, ability_match, acknowledge_match, idle_match, zero_match, consistency_match, timer_done;
  assign rx_masked = rx_config_reg & ~ACK;
  assign is_cfg = rudi == 2'b01;
  assign ability_match = abl_cnt == 2'd3;
  assign acknowledge_match = ability_match && &ack_hist;
  assign idle_match = idle_cnt == 2'd3;
  assign zero_match = ability_match && abl_word == '0;
  assign consistency_match = abl_word == stored_abl;
  assign timer_done = timer == TMR_LAST;
  // A count of 0 means no previous word exists, so any word restarts the run at 1.
  always_ff @(posedge clk) begin
    if (!mr_main_reset) begin
      abl_cnt <= '0;
      idle_cnt <= '0;
      ack_hist <= '0;
      abl_word <= '0;
    end else begin
      abl_cnt <= !is_cfg ? 2'd0 : (rx_masked != abl_word || abl_cnt == 2'd0) ? 2'd1 :
                 abl_cnt == 2'd3 ? 2'd3 : abl_cnt + 2'd1;
      abl_word <= is_cfg ? rx_masked : abl_word;
      ack_hist <= is_cfg ? {ack_hist[1:0], rx_config_reg[14]} : 3'd0;
      idle_cnt <= rudi != 2'b10 ? 2'd0 : idle_cnt == 2'd3 ? 2'd3 : idle_cnt + 2'd1;
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      AN_ENABLE: state_nx = mr_an_enable ? AN_RESTART : AN_DISABLE_LINK_OK;
      AN_RESTART: state_nx = timer_done ? ABILITY_DETECT : state;
      ABILITY_DETECT: state_nx = (ability_match && abl_word != '0) ? ACKNOWLEDGE_DETECT : state;
      ACKNOWLEDGE_DETECT: state_nx = acknowledge_match ? (consistency_match ? COMPLETE_ACKNOWLEDGE : AN_ENABLE) :
                                     zero_match ? AN_ENABLE : state;
      COMPLETE_ACKNOWLEDGE: state_nx = zero_match ? AN_ENABLE : timer_done ? IDLE_DETECT : state;
      IDLE_DETECT: state_nx = zero_match ? AN_ENABLE : (timer_done && idle_match) ? LINK_OK : state;
      LINK_OK: state_nx = ability_match ? AN_ENABLE : state;
      AN_DISABLE_LINK_OK: state_nx = mr_an_enable ? AN_ENABLE : state;
      default: state_nx = AN_ENABLE;
    endcase
    if (!mr_an_enable && state != AN_ENABLE && state != AN_DISABLE_LINK_OK) state_nx = AN_ENABLE;
    if (mr_restart_an || !sync_status) state_nx = AN_ENABLE;
    xmit_d = state_nx == IDLE_DETECT ? 3'b001 :
             (state_nx == LINK_OK || state_nx == AN_DISABLE_LINK_OK) ? 3'b010 : 3'b100;
    tx_d = (state_nx == AN_ENABLE || state_nx == AN_RESTART || state_nx == AN_DISABLE_LINK_OK) ? 16'h0000 :
           state_nx == ABILITY_DETECT ? mr_adv_ability & ~ACK : mr_adv_ability | ACK;
  end
  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!mr_main_reset) begin
      state <= AN_ENABLE;
      timer <= '0;
      stored_abl <= '0;
      xmit <= 3'b100;
      tx_config_reg <= '0;
      mr_an_complete <= 1'b0;
      mr_page_rx <= 1'b0;
      mr_lp_adv_ability <= '0;
    end else begin
      state <= state_nx;
      timer <= state_nx != state ? '0 : timer_done ? timer : timer + TMR_W'(1);
      stored_abl <= (state == ABILITY_DETECT && state_nx == ACKNOWLEDGE_DETECT) ? abl_word : stored_abl;
      mr_lp_adv_ability <= (state != COMPLETE_ACKNOWLEDGE && state_nx == COMPLETE_ACKNOWLEDGE) ? stored_abl : mr_lp_adv_ability;
      xmit <= xmit_d;
      tx_config_reg <= tx_d;
      mr_an_complete <= state_nx == LINK_OK;
      mr_page_rx <= state_nx == COMPLETE_ACKNOWLEDGE || state_nx == IDLE_DETECT || state_nx == LINK_OK;
    end
  end
endmodule

// File: tb/tb_an_xmit_controller.sv
// tb_an_xmit_controller: vector table, directed negotiation sequences and randomized partner traffic
module tb_an_xmit_controller;
  localparam int L = 8;
  localparam logic [15:0] MASK = 16'hBFFF;
  logic clk = 1'b0;
  logic rst_n, an_en, restart, sync;
  logic [15:0] adv, rx;
  logic [1:0] rudi;
  logic [2:0] xmit;
  logic [15:0] tx, lp;
  logic cmp, page;
  int checks = 0;
  int passes = 0;
  always #5 clk = ~clk;
  an_xmit_controller #(.LINK_TIMER(L), .TMR_W(16)) dut (
    .clk(clk), .mr_main_reset(rst_n), .mr_an_enable(an_en), .mr_restart_an(restart),
    .sync_status(sync), .mr_adv_ability(adv), .rudi(rudi), .rx_config_reg(rx),
    .xmit(xmit), .tx_config_reg(tx), .mr_an_complete(cmp), .mr_page_rx(page),
    .mr_lp_adv_ability(lp)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [15:0] w, input int n);
    repeat (n) begin
      rudi = 2'b01;
      rx = w;
      tick();
    end
  endtask
  task automatic wait_x(input logic [2:0] x, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (xmit === x) begin
        n = i;
        break;
      end
    end
  endtask
  task automatic wait_ability(input string name);
    bit found = 0;
    rudi = 2'b00;
    rx = 16'h0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      found = xmit === 3'b100 && tx === (adv & MASK);
    end
    check(name, 64'(found), 64'(1));
  endtask
  task automatic negotiate(input string tag);
    int n;
    wait_ability({tag, "_reach_ability"});
    send(16'h01E0, 3);
    send(16'h41E0, 1);
    check({tag, "_ack_tx"}, 64'(tx), 64'(16'h41A0));
    check({tag, "_ack_page"}, 64'(page), 64'(0));
    send(16'h41E0, 2);
    rudi = 2'b10;
    rx = 16'h0;
    tick();
    check({tag, "_page_rx"}, 64'({page, xmit}), 64'({1'b1, 3'b100}));
    check({tag, "_lp_adv"}, 64'(lp), 64'(16'h01E0));
    wait_x(3'b001, 40, n);
    check({tag, "_idle_delay"}, 64'(n), 64'(L));
    wait_x(3'b010, 40, n);
    check({tag, "_link_delay"}, 64'(n), 64'(L));
    check({tag, "_complete"}, 64'(cmp), 64'(1));
  endtask
  typedef struct {
    logic rst_n, en, rs, sy;
    logic [2:0] x;
  } vec_t;
  vec_t tbl[14];
  typedef enum int {M_EN, M_RS, M_AB, M_AK, M_CA, M_ID, M_OK, M_DIS} mst_t;
  mst_t ms;
  int dwell;
  logic [17:0] hist[$];
  logic [15:0] m_stored, m_lp, m_tx;
  logic [2:0] m_x;
  logic m_c, m_p;
  function automatic bit all_rudi(input logic [1:0] r);
    if (hist.size() < 3) return 0;
    foreach (hist[i]) if (hist[i][17:16] != r) return 0;
    return 1;
  endfunction
  // Reference: decisions come from the last three received samples and the time spent in a state.
  task automatic model_step();
    bit ab, ak, idl, zero, done;
    logic [15:0] w;
    mst_t nx;
    if (!rst_n) begin
      ms = M_EN; dwell = 0; hist.delete(); m_stored = 0; m_lp = 0;
      m_x = 3'b100; m_tx = 0; m_c = 0; m_p = 0;
      return;
    end
    ab = all_rudi(2'b01) && (hist[0][15:0] & MASK) == (hist[1][15:0] & MASK) &&
         (hist[1][15:0] & MASK) == (hist[2][15:0] & MASK);
    w = ab ? hist[0][15:0] & MASK : 16'h0;
    ak = ab && hist[0][14] && hist[1][14] && hist[2][14];
    zero = ab && w == 16'h0;
    idl = all_rudi(2'b10);
    done = dwell >= L - 1;
    nx = ms;
    case (ms)
      M_EN: nx = an_en ? M_RS : M_DIS;
      M_RS: if (done) nx = M_AB;
      M_AB: if (ab && w != 0) nx = M_AK;
      M_AK: if (ak) nx = (w == m_stored) ? M_CA : M_EN; else if (zero) nx = M_EN;
      M_CA: if (zero) nx = M_EN; else if (done) nx = M_ID;
      M_ID: if (zero) nx = M_EN; else if (done && idl) nx = M_OK;
      M_OK: if (ab) nx = M_EN;
      M_DIS: if (an_en) nx = M_EN;
      default: nx = M_EN;
    endcase
    if (!an_en && ms != M_EN && ms != M_DIS) nx = M_EN;
    if (restart || !sync) nx = M_EN;
    if (ms == M_AB && nx == M_AK) m_stored = w;
    if (ms != M_CA && nx == M_CA) m_lp = m_stored;
    dwell = (nx == ms) ? dwell + 1 : 0;
    ms = nx;
    hist.push_front({rudi, rx});
    if (hist.size() > 3) void'(hist.pop_back());
    m_x = ms == M_ID ? 3'b001 : (ms == M_OK || ms == M_DIS) ? 3'b010 : 3'b100;
    m_tx = (ms == M_EN || ms == M_RS || ms == M_DIS) ? 16'h0 : ms == M_AB ? adv & MASK : adv | 16'h4000;
    m_c = ms == M_OK;
    m_p = ms == M_CA || ms == M_ID || ms == M_OK;
  endtask
  task automatic rand_cycle(input logic [1:0] r, input logic [15:0] w, input bit force_rst);
    rudi = r;
    rx = w;
    rst_n = force_rst ? 1'b0 : ($urandom_range(0, 999) != 0);
    restart = $urandom_range(0, 299) == 0;
    sync = $urandom_range(0, 299) != 0;
    an_en = $urandom_range(0, 149) != 0;
    @(posedge clk);
    model_step();
    #1;
    check("rand_cyc", 64'({xmit, tx, cmp, page, lp}), 64'({m_x, m_tx, m_c, m_p, m_lp}));
  endtask
  logic [15:0] words[4] = '{16'h01E0, 16'h01A0, 16'h0000, 16'h8021};
  initial begin
    rst_n = 0; an_en = 0; restart = 0; sync = 1; adv = 16'h01A0; rudi = 0; rx = 0;
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b100};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b100};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b100};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b010};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b010};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 3'b100};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 3'b100};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b100};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b010};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'b100};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b100};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'b100};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b100};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b010};
    for (int i = 0; i < 14; i++) begin
      rst_n = tbl[i].rst_n; an_en = tbl[i].en; restart = tbl[i].rs; sync = tbl[i].sy;
      tick();
      check($sformatf("tbl%0d", i), 64'({xmit, tx, cmp, page}), 64'({tbl[i].x, 16'h0, 1'b0, 1'b0}));
    end
    restart = 0; sync = 1; rst_n = 0; an_en = 1;
    tick();
    tick();
    check("reset_lp", 64'(lp), 64'(0));
    rst_n = 1;
    negotiate("neg1");
    send(16'h0000, 4);
    check("prst_enable", 64'({xmit, tx, cmp}), 64'({3'b100, 16'h0, 1'b0}));
    rudi = 2'b00;
    tick();
    check("prst_restart", 64'({xmit, tx, cmp, page}), 64'({3'b100, 16'h0, 1'b0, 1'b0}));
    negotiate("neg2");
    restart = 1;
    tick();
    restart = 0;
    check("restart_pulse", 64'({xmit, cmp, page}), 64'({3'b100, 1'b0, 1'b0}));
    wait_ability("sync_reach");
    send(16'h01E0, 3);
    send(16'h41E0, 3);
    rudi = 2'b10;
    tick();
    tick();
    tick();
    check("sync_in_complete", 64'(page), 64'(1));
    sync = 0;
    tick();
    sync = 1;
    check("sync_loss", 64'({xmit, tx, cmp, page}), 64'({3'b100, 16'h0, 1'b0, 1'b0}));
    wait_ability("inc_reach");
    send(16'h01E0, 3);
    send(16'h41E8, 1);
    check("inc_ack_entry", 64'(tx), 64'(16'h41A0));
    send(16'h41E8, 2);
    rudi = 2'b10;
    tick();
    check("inconsistent", 64'({xmit, tx, page}), 64'({3'b100, 16'h0, 1'b0}));
    wait_ability("glitch_reach");
    send(16'h01E0, 2);
    send(16'h01E4, 1);
    send(16'h01E0, 3);
    check("glitch_hold", 64'(tx), 64'(16'h01A0));
    send(16'h01E0, 1);
    check("glitch_exit", 64'(tx), 64'(16'h41A0));
    rudi = 2'b00;
    rand_cycle(2'b00, 16'h0, 1'b1);
    for (int ep = 0; ep < 150; ep++) begin
      logic [15:0] base, ackw;
      int sel;
      if ($urandom_range(0, 3) == 0) adv = words[$urandom_range(0, 3)] ^ 16'($urandom_range(0, 1) << 14);
      base = words[$urandom_range(0, 3)];
      sel = $urandom_range(0, 7);
      ackw = sel < 6 ? base | 16'h4000 : sel == 6 ? (base ^ 16'h0008) | 16'h4000 : base;
      repeat ($urandom_range(1, 5)) rand_cycle(2'b01, base, 1'b0);
      repeat ($urandom_range(1, 5)) rand_cycle(2'b01, ackw, 1'b0);
      repeat ($urandom_range(0, 25)) rand_cycle(2'b10, 16'h0, 1'b0);
      repeat ($urandom_range(0, 4)) rand_cycle(2'($urandom_range(0, 3)), 16'($urandom), 1'b0);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
